dp2_requant_pipe: RTL

//  Requantizes the 32-bit per-channel accumulators of depthwise-pointwise layer 2 to int8.

---
 rtl/cnn_quant_pkg.sv | 11 +
 rtl/dp2_requant_pipe_round_sat.sv | 61 ++++++
 rtl/dp2_requant_pipe.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cnn_quant_pkg.sv
// Shared quantization types and limits for the CNN int8 datapaths.
package cnn_quant_pkg;

    localparam int INT8_MIN = -128;
    localparam int INT8_MAX = 127;
    localparam int ACC_W    = 32;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [7:0]       q8_t;

endpackage

// File: rtl/dp2_requant_pipe_round_sat.sv
// requant_round_sat: combinational round-half-up, arithmetic shift, zero-point
// add and int8 saturation for the DP2 requantizer output stage.
// Optional macro DP2_REQUANT_RELU_EN fuses a ReLU clamp at max(ZERO_POINT,-128).
module requant_round_sat
    import cnn_quant_pkg::*;
#(
    parameter int PROD_W     = 41,
    parameter int SHIFT      = 7,
    parameter int ZERO_POINT = 0
) (
    input  logic signed [PROD_W-1:0] prod,
    output logic signed [7:0]        q
);

    // Two guard bits: one for the rounding add, one for the zero-point add.
    localparam int RW = PROD_W + 2;

    typedef logic signed [RW-1:0] wide_t;

    localparam wide_t HALF   = wide_t'(2 ** (SHIFT - 1));
    localparam wide_t ZP     = wide_t'(ZERO_POINT);
    localparam wide_t SAT_HI = wide_t'(INT8_MAX);
    localparam wide_t SAT_LO = wide_t'(INT8_MIN);

`ifdef DP2_REQUANT_RELU_EN
    localparam int  RELU_FLOOR_I = (ZERO_POINT > INT8_MIN) ? ZERO_POINT : INT8_MIN;
    localparam q8_t RELU_FLOOR   = q8_t'(RELU_FLOOR_I);

    function automatic q8_t relu_clamp(input q8_t x);
        return (x < RELU_FLOOR) ? RELU_FLOOR : x;
    endfunction
`endif

    // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
    function automatic wide_t round_shift(input wide_t x);
        return (x + HALF) >>> SHIFT;
    endfunction

    function automatic q8_t sat_q8(input wide_t x);
        if (x > SAT_HI) begin
            return q8_t'(INT8_MAX);
        end else if (x < SAT_LO) begin
            return q8_t'(INT8_MIN);
        end else begin
            return $signed(x[7:0]);
        end
    endfunction

    wide_t r;

    // Round, shift, offset, saturate (and optionally clamp) the exact product.
    always_comb begin
        r = round_shift(wide_t'(prod)) + ZP;
`ifdef DP2_REQUANT_RELU_EN
        q = relu_clamp(sat_q8(r));
`else
        q = sat_q8(r);
`endif
    end

endmodule

// File: rtl/dp2_requant_pipe.sv
// dp2_requant_pipe: requantizes DP2 pointwise accumulators to int8 through a
// 3-stage valid/ready pipeline (capture, multiply, round/saturate) with an
// internal channel counter addressing the per-channel scale ROM.
// Optional macro DP2_REQUANT_RELU_EN enables the fused ReLU in the output stage.
module dp2_requant_pipe #(
    parameter int ACC_W      = 32,
    parameter int NUM_CH     = 64,
    parameter int CH_W       = $clog2(NUM_CH),
    parameter int SHIFT      = 7,
    parameter int ZERO_POINT = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [ACC_W-1:0] in_acc,
    input  logic                    in_last,
    output logic [CH_W-1:0]         rom_addr,
    input  logic [7:0]              rom_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [7:0]       out_data,
    output logic [CH_W-1:0]         out_ch,
    output logic                    out_last,
    output logic                    err_align
);

    import cnn_quant_pkg::*;

    // Signed accumulator times a zero-extended 8-bit scale needs ACC_W+9 bits.
    localparam int              PROD_W  = ACC_W + 9;
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

    logic                     adv;
    logic                     accept;
    logic [CH_W-1:0]          ch_cnt;

    logic                     vld_p0;
    logic                     vld_p1;
    logic                     vld_p2;

    logic signed [ACC_W-1:0]  acc_p0;
    logic [7:0]               scale_p0;
    logic [CH_W-1:0]          ch_p0;
    logic                     last_p0;

    logic signed [PROD_W-1:0] prod_p1;
    logic [CH_W-1:0]          ch_p1;
    logic                     last_p1;

    q8_t                      q_p1;

    // Whole pipeline moves in lockstep; bubbles travel rather than collapse.
    assign adv       = !vld_p2 || out_ready;
    assign in_ready  = adv;
    assign accept    = in_valid && adv;
    assign rom_addr  = ch_cnt;
    assign out_valid = vld_p2;

    // Valid shift register, channel counter and sticky alignment error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            ch_cnt    <= '0;
            err_align <= 1'b0;
        end else begin
            if (adv) begin
                vld_p0 <= accept;
                vld_p1 <= vld_p0;
                vld_p2 <= vld_p1;
            end
            if (accept) begin
                if (in_last || (ch_cnt == CH_LAST)) begin
                    ch_cnt <= '0;
                end else begin
                    ch_cnt <= ch_cnt + 1'b1;
                end
                if (in_last && (ch_cnt != CH_LAST)) begin
                    err_align <= 1'b1;
                end
            end
        end
    end

    // ---- stage p0: capture accumulator with its channel's scale ----
    // Capture the accepted beat together with the scale read for its channel.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc_p0   <= in_acc;
            scale_p0 <= rom_data;
            ch_p0    <= ch_cnt;
            last_p0  <= in_last;
        end
    end

    // ---- stage p1: exact signed product ----
    // Exact product; scale is unsigned so it is zero-extended before the signed multiply.
    always_ff @(posedge clk) begin
        if (adv) begin
            prod_p1 <= PROD_W'(acc_p0) * $signed({{(PROD_W-8){1'b0}}, scale_p0});
            ch_p1   <= ch_p0;
            last_p1 <= last_p0;
        end
    end

    requant_round_sat #(
        .PROD_W     (PROD_W),
        .SHIFT      (SHIFT),
        .ZERO_POINT (ZERO_POINT)
    ) u_round_sat (
        .prod (prod_p1),
        .q    (q_p1)
    );

    // ---- stage p2: registered int8 result ----
    // Output registers load only with a real beat and hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_ch   <= '0;
            out_last <= 1'b0;
        end else if (adv && vld_p1) begin
            out_data <= q_p1;
            out_ch   <= ch_p1;
            out_last <= last_p1;
        end
    end

endmodule
